// File: rtl/data_table_delete_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_table_delete_pkg
// Description : Shared types for the hash table delete engine: command,
//               task, result and data RAM entry layouts, result codes and
//               the delete FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package data_table_delete_pkg;

  localparam int KEY_WIDTH        = 8;
  localparam int VALUE_WIDTH      = 16;
  localparam int BUCKET_WIDTH     = 4;
  localparam int TABLE_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_SEARCH = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2
  } ht_opcode_t;

  typedef enum logic [2:0] {
    SEARCH_FOUND                     = 3'd0,
    SEARCH_NOT_SUCCESS_NO_ENTRY      = 3'd1,
    INSERT_SUCCESS                   = 3'd2,
    INSERT_SUCCESS_SAME_KEY          = 3'd3,
    INSERT_NOT_SUCCESS_TABLE_IS_FULL = 3'd4,
    DELETE_SUCCESS                   = 3'd5,
    DELETE_NOT_SUCCESS_NO_ENTRY      = 3'd6
  } ht_rescode_t;

  typedef struct packed {
    ht_opcode_t             opcode;
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
  } ht_command_t;

  // Task handed over by the arbiter with the bucket head already resolved.
  typedef struct packed {
    ht_command_t                 cmd;
    logic [BUCKET_WIDTH-1:0]     bucket;
    logic [TABLE_ADDR_WIDTH-1:0] head_ptr;
    logic                        head_ptr_val;
  } ht_pdata_t;

  typedef struct packed {
    ht_command_t             cmd;
    logic [VALUE_WIDTH-1:0]  found_value;
    logic [BUCKET_WIDTH-1:0] bucket;
    ht_rescode_t             rescode;
  } ht_result_t;

  // One chain element as stored in data RAM.
  typedef struct packed {
    logic [KEY_WIDTH-1:0]        key;
    logic [VALUE_WIDTH-1:0]      value;
    logic [TABLE_ADDR_WIDTH-1:0] next_ptr;
    logic                        next_ptr_val;
  } ram_data_t;

  typedef enum logic [2:0] {
    IDLE_S        = 3'd0,
    READ_HEAD_S   = 3'd1,
    GO_ON_CHAIN_S = 3'd2,
    UPD_HEAD_S    = 3'd3,
    UPD_PREV_S    = 3'd4,
    CLEAR_S       = 3'd5,
    DELETE_DONE_S = 3'd6,
    NO_ENTRY_S    = 3'd7
  } del_state_t;

  function automatic logic key_match(input ram_data_t entry,
                                     input logic [KEY_WIDTH-1:0] key);
    return entry.key == key;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_table_delete_if.sv
`default_nettype none
// ============================================================================
// Module      : data_table_delete_if
// Description : Head table write port. The delete engine drives it as master
//               when the matched entry sits at the head of its bucket.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_table_delete_if;
  import data_table_delete_pkg::*;

  logic [BUCKET_WIDTH-1:0]     wr_addr;
  logic [TABLE_ADDR_WIDTH-1:0] wr_data_ptr;
  logic                        wr_data_ptr_val;
  logic                        wr_en;

  modport master (
    output wr_addr,
    output wr_data_ptr,
    output wr_data_ptr_val,
    output wr_en
  );

  modport slave (
    input wr_addr,
    input wr_data_ptr,
    input wr_data_ptr_val,
    input wr_en
  );

endinterface
`default_nettype wire

// File: rtl/data_table_delete_rd_data_val_helper.sv
`default_nettype none
// ============================================================================
// Module      : data_table_delete_rd_data_val_helper
// Description : Delays the data RAM read strobe by the RAM read latency so
//               the engine knows in which cycle rd_data is valid.
// Revision    : 1.0 - initial release
// ============================================================================
module data_table_delete_rd_data_val_helper #(
  parameter int RAM_LATENCY = 2
) (
  input  wire logic clk_i,
  input  wire logic rst_n_i,
  input  wire logic rd_en_i,
  output logic      rd_data_val_o
);

  logic [RAM_LATENCY-1:0] r_pipe;

  generate
    if (RAM_LATENCY == 1) begin : g_lat_one
      // Single-stage delay of the read strobe.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_pipe <= '0;
        else          r_pipe <= rd_en_i;
      end
    end else begin : g_lat_multi
      // Shift the read strobe through RAM_LATENCY stages.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_pipe <= '0;
        else          r_pipe <= {r_pipe[RAM_LATENCY-2:0], rd_en_i};
      end
    end
  endgenerate

  assign rd_data_val_o = r_pipe[RAM_LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/data_table_delete.sv
`default_nettype none
// ============================================================================
// Module      : data_table_delete
// Description : Hash table delete engine. Walks a bucket chain in data RAM,
//               unlinks the matching entry (head table or predecessor),
//               clears it and returns its address to empty pointer storage.
//               The unlink write always precedes the clear so concurrent
//               searches never follow a pointer into a freed entry.
// Revision    : 1.0 - initial release
// ============================================================================
module data_table_delete
  import data_table_delete_pkg::*;
#(
  parameter int RAM_LATENCY = 2,
  parameter int A_WIDTH     = TABLE_ADDR_WIDTH
) (
  input  wire logic            clk_i,
  input  wire logic            rst_n_i,

  input  wire ht_pdata_t       task_i,
  input  wire logic            task_valid_i,
  output logic                 task_ready_o,

  input  wire ram_data_t       rd_data_i,
  output logic [A_WIDTH-1:0]   rd_addr_o,
  output logic                 rd_en_o,

  output logic [A_WIDTH-1:0]   wr_addr_o,
  output ram_data_t            wr_data_o,
  output logic                 wr_en_o,

  output logic [A_WIDTH-1:0]   empty_addr_o,
  output logic                 empty_addr_add_o,

  data_table_delete_if.master  head_table_if,

  output ht_result_t           result_o,
  output logic                 result_valid_o,
  input  wire logic            result_ready_i
);

  del_state_t                  r_state;
  del_state_t                  w_state_next;

  // Locked task fields.
  ht_command_t                 r_cmd;
  logic [BUCKET_WIDTH-1:0]     r_bucket;

  // Chain walk context.
  logic [A_WIDTH-1:0]          r_cur_addr;
  logic [A_WIDTH-1:0]          r_prev_addr;
  ram_data_t                   r_prev_data;
  logic                        r_prev_val;
  logic                        r_rd_req;

  // Fields of the matched entry still needed after the walk.
  logic [TABLE_ADDR_WIDTH-1:0] r_match_next_ptr;
  logic                        r_match_next_val;
  logic [VALUE_WIDTH-1:0]      r_match_value;

  logic                        w_rd_data_val;
  logic                        w_in_read;
  logic                        w_accept;
  logic                        w_key_match;
  ht_rescode_t                 w_rescode;
  logic [VALUE_WIDTH-1:0]      w_found_value;

  data_table_delete_rd_data_val_helper #(
    .RAM_LATENCY (RAM_LATENCY)
  ) u_rd_data_val_helper (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .rd_en_i       (rd_en_o),
    .rd_data_val_o (w_rd_data_val)
  );

  assign w_in_read   = (r_state == READ_HEAD_S) || (r_state == GO_ON_CHAIN_S);
  assign w_accept    = task_valid_i && (r_state == IDLE_S);
  assign w_key_match = key_match(rd_data_i, r_cmd.key);
  assign rd_addr_o   = r_cur_addr;

  assign result_o = '{cmd:         r_cmd,
                      found_value: w_found_value,
                      bucket:      r_bucket,
                      rescode:     w_rescode};

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= IDLE_S;
    else          r_state <= w_state_next;
  end

  // Task lock and chain walk bookkeeping.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cmd            <= '0;
      r_bucket         <= '0;
      r_cur_addr       <= '0;
      r_prev_addr      <= '0;
      r_prev_data      <= '0;
      r_prev_val       <= 1'b0;
      r_rd_req         <= 1'b0;
      r_match_next_ptr <= '0;
      r_match_next_val <= 1'b0;
      r_match_value    <= '0;
    end else if (w_accept) begin
      r_cmd      <= task_i.cmd;
      r_bucket   <= task_i.bucket;
      r_cur_addr <= A_WIDTH'(task_i.head_ptr);
      r_prev_val <= 1'b0;
      // The first read of the walk is requested only for a non-empty bucket.
      r_rd_req   <= task_i.head_ptr_val;
    end else if (w_in_read) begin
      if (rd_en_o) begin
        r_rd_req <= 1'b0;
      end
      if (w_rd_data_val) begin
        if (w_key_match) begin
          r_match_next_ptr <= rd_data_i.next_ptr;
          r_match_next_val <= rd_data_i.next_ptr_val;
          r_match_value    <= rd_data_i.value;
        end else if (rd_data_i.next_ptr_val) begin
          // Step along the chain; the current entry becomes the predecessor.
          r_prev_addr <= r_cur_addr;
          r_prev_data <= rd_data_i;
          r_prev_val  <= 1'b1;
          r_cur_addr  <= A_WIDTH'(rd_data_i.next_ptr);
          r_rd_req    <= 1'b1;
        end
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_state_next                  = r_state;
    task_ready_o                  = 1'b0;
    rd_en_o                       = 1'b0;
    wr_en_o                       = 1'b0;
    wr_addr_o                     = r_cur_addr;
    wr_data_o                     = '0;
    empty_addr_add_o              = 1'b0;
    empty_addr_o                  = r_cur_addr;
    head_table_if.wr_en           = 1'b0;
    head_table_if.wr_addr         = r_bucket;
    head_table_if.wr_data_ptr     = r_match_next_ptr;
    head_table_if.wr_data_ptr_val = r_match_next_val;
    result_valid_o                = 1'b0;
    w_rescode                     = DELETE_NOT_SUCCESS_NO_ENTRY;
    w_found_value                 = '0;

    case (r_state)
      IDLE_S: begin
        task_ready_o = 1'b1;
        if (task_valid_i) begin
          w_state_next = task_i.head_ptr_val ? READ_HEAD_S : NO_ENTRY_S;
        end
      end

      READ_HEAD_S, GO_ON_CHAIN_S: begin
        rd_en_o = r_rd_req;
        if (w_rd_data_val) begin
          if (w_key_match) begin
            w_state_next = r_prev_val ? UPD_PREV_S : UPD_HEAD_S;
          end else if (!rd_data_i.next_ptr_val) begin
            w_state_next = NO_ENTRY_S;
          end else begin
            w_state_next = GO_ON_CHAIN_S;
          end
        end
      end

      UPD_HEAD_S: begin
        head_table_if.wr_en = 1'b1;
        w_state_next        = CLEAR_S;
      end

      UPD_PREV_S: begin
        wr_en_o                = 1'b1;
        wr_addr_o              = r_prev_addr;
        wr_data_o              = r_prev_data;
        wr_data_o.next_ptr     = r_match_next_ptr;
        wr_data_o.next_ptr_val = r_match_next_val;
        w_state_next           = CLEAR_S;
      end

      CLEAR_S: begin
        wr_en_o          = 1'b1;
        wr_addr_o        = r_cur_addr;
        wr_data_o        = '0;
        empty_addr_add_o = 1'b1;
        empty_addr_o     = r_cur_addr;
        w_state_next     = DELETE_DONE_S;
      end

      DELETE_DONE_S: begin
        result_valid_o = 1'b1;
        w_rescode      = DELETE_SUCCESS;
        w_found_value  = r_match_value;
        if (result_ready_i) w_state_next = IDLE_S;
      end

      NO_ENTRY_S: begin
        result_valid_o = 1'b1;
        w_rescode      = DELETE_NOT_SUCCESS_NO_ENTRY;
        if (result_ready_i) w_state_next = IDLE_S;
      end

      default: begin
        w_state_next = IDLE_S;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/data_table_delete.md
Name: data_table_delete

Overview:
- Delete engine of the hash table data path; the inverse of the insert engine.
- Accepts a delete task with the bucket head pointer already resolved, and walks the bucket chain in data RAM looking for the key.
- On a hit it unlinks the entry, either through the head table or through the predecessor's next_ptr, then clears the entry and returns its address to empty pointer storage.
- Sits beside the search/insert engines behind the same command arbiter and shares data RAM, head table and empty-pointer storage through the top-level mux.

Parameters:
- RAM_LATENCY, 2, data RAM read latency in cycles; rd_data_i is valid this many cycles after rd_en_o.
- A_WIDTH, TABLE_ADDR_WIDTH, data RAM / pointer address width.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- task_i  in  ht_pdata_t  delete command: cmd.key, bucket, head_ptr, head_ptr_val.
- task_valid_i  in  1  task valid.
- task_ready_o  out  1  task accepted when valid&&ready.
- rd_data_i  in  ram_data_t  data RAM read data.
- rd_addr_o  out  A_WIDTH  data RAM read address.
- rd_en_o  out  1  data RAM read strobe.
- wr_addr_o  out  A_WIDTH  data RAM write address.
- wr_data_o  out  ram_data_t  data RAM write data.
- wr_en_o  out  1  data RAM write strobe, single cycle.
- empty_addr_o  out  A_WIDTH  freed address returned to empty pointer storage.
- empty_addr_add_o  out  1  one-cycle push of empty_addr_o; storage never back-pressures.
- head_table_if  master  head_table_if  head table write port: wr_addr, wr_data_ptr, wr_data_ptr_val, wr_en.
- result_o  out  ht_result_t  cmd, bucket, rescode; found_value is the deleted value on success, else 0.
- result_valid_o  out  1  result valid.
- result_ready_i  in  1  result consumer ready.

Behaviour:
- Reset (async, rst_n_i=0): state=IDLE_S; all strobes (rd_en_o, wr_en_o, empty_addr_add_o, head_table_if.wr_en, result_valid_o) = 0; task_ready_o=1 after reset release; locked task, addresses and locked read data cleared to 0.
- Reset mid-operation abandons the walk. No partial-unlink recovery is provided; the top level resets all table blocks together.
- task_ready_o = (state==IDLE_S). The task is locked on accept.
- States:
  - IDLE_S: on accept, go to NO_ENTRY_S if !head_ptr_val, else READ_HEAD_S with cur_addr=head_ptr and prev_val=0.
  - READ_HEAD_S / GO_ON_CHAIN_S: issue one rd_en_o on the first tick of the state and again on the tick after each rd_data_val; wait RAM_LATENCY cycles. On rd_data_val:
    - key match and prev_val=0 -> UPD_HEAD_S.
    - key match and prev_val=1 -> UPD_PREV_S.
    - no match and next_ptr_val=0 -> NO_ENTRY_S.
    - otherwise set prev_addr=cur_addr, prev_data=rd_data_i, prev_val=1, cur_addr=next_ptr, and go to GO_ON_CHAIN_S.
  - The matched entry is locked as match_data.
  - UPD_HEAD_S (1 cycle): head_table_if.wr_en=1, wr_addr=bucket, wr_data_ptr=match_data.next_ptr, wr_data_ptr_val=match_data.next_ptr_val. Then -> CLEAR_S.
  - UPD_PREV_S (1 cycle): wr_en_o=1, wr_addr_o=prev_addr, wr_data_o=prev_data with next_ptr/next_ptr_val taken from match_data. Then -> CLEAR_S.
  - CLEAR_S (1 cycle): wr_en_o=1, wr_addr_o=cur_addr, wr_data_o='0; empty_addr_add_o=1, empty_addr_o=cur_addr. Then -> DELETE_DONE_S.
  - DELETE_DONE_S: result_valid_o=1, rescode=DELETE_SUCCESS, found_value=match_data.value. Go to IDLE_S on result_ready_i.
  - NO_ENTRY_S: result_valid_o=1, rescode=DELETE_NOT_SUCCESS_NO_ENTRY, found_value=0. Go to IDLE_S on result_ready_i.
- Ordering: the unlink write (head or predecessor) always precedes the clear and the pointer return, so a concurrent search can never follow a pointer into a freed entry.
- result_o and result_valid_o are held stable while result_ready_i is low. No new task is accepted until the result is taken.
- At most one of wr_en_o and head_table_if.wr_en is asserted per cycle. rd_en_o is never asserted outside READ_HEAD_S / GO_ON_CHAIN_S.
- Chain length is unbounded by this block; a chain cycle is a table-integrity error and is out of scope.
- Minimum latency, accept to result_valid_o:
  - miss on empty bucket: 1 cycle.
  - hit at head: 1 + RAM_LATENCY + 3 cycles.

Decomposition:
- hash_table package: ht_pdata_t, ht_result_t, ram_data_t and TABLE_ADDR_WIDTH, plus new rescodes DELETE_SUCCESS and DELETE_NOT_SUCCESS_NO_ENTRY in the rescode enum.
- Sub-module: existing rd_data_val_helper (RAM_LATENCY) generates rd_data_val from rd_en_o. No other sub-modules.

Test Plan:
- Empty bucket: head_ptr_val=0, key=0x11 -> no rd_en_o, no writes; result NO_ENTRY one cycle after accept.
- Chain bucket3 = [A5:key 0x11, next_ptr_val=0], delete 0x11 -> head write (bucket 3, ptr_val=0), then wr 0 @5, then empty_addr_o=5; result SUCCESS, found_value = stored value.
- Chain 5(0x11)->9(0x22)->2(0x33), delete 0x22 -> 2 reads; wr @5 with next_ptr=2, ptr_val=1; wr 0 @9; empty_addr_o=9; SUCCESS.
- Same chain, delete 0x33 -> 3 reads; wr @9 with next_ptr_val=0; clear @2; return 2. Delete 0x44 -> 3 reads, no writes, NO_ENTRY.
- Back-pressure: result_ready_i=0 for 10 cycles -> result_o stable, task_ready_o=0; ready=1 -> IDLE_S next cycle.
- Assert rst_n_i during GO_ON_CHAIN_S -> all strobes 0 immediately; task_ready_o=1 after release; a following delete completes correctly.
